// File: rtl/ex_muldiv.sv
// Multi-cycle multiply/divide unit for the EX stage: shift-add multiply and
// restoring divide, one bit per cycle, with results held in HI/LO registers.
module ex_muldiv #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic [1:0]        op_i,
  input  logic [DATA_W-1:0] opdata1_i,
  input  logic [DATA_W-1:0] opdata2_i,
  input  logic              annul_i,
  output logic              stallreq,
  output logic              done_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              div_zero_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE, DZERO} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [2*DATA_W-1:0] acc;      // {remainder, quotient} or {partial product, multiplier}
  logic [DATA_W-1:0]   opb;      // multiplicand or divisor magnitude
  logic                is_div;
  logic                neg_q;
  logic                neg_r;

  // Operand decode for the acceptance cycle
  logic              signed_op;
  logic              div_op;
  logic              a_neg;
  logic              b_neg;
  logic [DATA_W-1:0] a_mag;
  logic [DATA_W-1:0] b_mag;

  always_comb begin
    signed_op = ~op_i[0];
    div_op    = op_i[1];
    a_neg     = signed_op & opdata1_i[DATA_W-1];
    b_neg     = signed_op & opdata2_i[DATA_W-1];
    a_mag     = a_neg ? (~opdata1_i + 1'b1) : opdata1_i;
    b_mag     = b_neg ? (~opdata2_i + 1'b1) : opdata2_i;
  end

  // One iteration of either algorithm, plus the sign-corrected final result
  logic [DATA_W-1:0]   mul_addend;
  logic [DATA_W:0]     mul_sum;
  logic [2*DATA_W-1:0] mul_next;
  logic [DATA_W:0]     div_shift;
  logic [DATA_W:0]     div_diff;
  logic [2*DATA_W-1:0] div_next;
  logic [2*DATA_W-1:0] step_next;
  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W-1:0]   quo_fix;
  logic [DATA_W-1:0]   rem_fix;
  logic [DATA_W-1:0]   final_hi;
  logic [DATA_W-1:0]   final_lo;

  always_comb begin
    mul_addend = acc[0] ? opb : {DATA_W{1'b0}};
    mul_sum    = {1'b0, acc[2*DATA_W-1:DATA_W]} + {1'b0, mul_addend};
    mul_next   = {mul_sum, acc[DATA_W-1:1]};

    div_shift  = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]};
    div_diff   = div_shift - {1'b0, opb};
    // A borrow out of the trial subtraction restores the shifted remainder
    if (div_diff[DATA_W])
      div_next = {div_shift[DATA_W-1:0], acc[DATA_W-2:0], 1'b0};
    else
      div_next = {div_diff[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};

    step_next = is_div ? div_next : mul_next;

    prod_fix = neg_q ? (~step_next + 1'b1) : step_next;
    quo_fix  = neg_q ? (~step_next[DATA_W-1:0] + 1'b1) : step_next[DATA_W-1:0];
    rem_fix  = neg_r ? (~step_next[2*DATA_W-1:DATA_W] + 1'b1)
                     : step_next[2*DATA_W-1:DATA_W];

    if (is_div) begin
      final_hi = rem_fix;
      final_lo = quo_fix;
    end else begin
      final_hi = prod_fix[2*DATA_W-1:DATA_W];
      final_lo = prod_fix[DATA_W-1:0];
    end
  end

  // Stall drops in DONE so the instruction advances as its result lands
  always_comb begin
    stallreq = (state == RUN) || ((state == IDLE) && start_i && !annul_i);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      acc        <= '0;
      opb        <= '0;
      is_div     <= 1'b0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      done_o     <= 1'b0;
      hi_o       <= '0;
      lo_o       <= '0;
      div_zero_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (annul_i) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start_i) begin
              is_div <= div_op;
              neg_q  <= a_neg ^ b_neg;
              neg_r  <= a_neg;
              opb    <= div_op ? b_mag : a_mag;
              acc    <= {{DATA_W{1'b0}}, (div_op ? a_mag : b_mag)};
              cnt    <= CNT_W'(DATA_W);
              if (div_op && (opdata2_i == '0)) begin
                state      <= DZERO;
                hi_o       <= '0;
                lo_o       <= '0;
                div_zero_o <= 1'b1;
                done_o     <= 1'b1;
              end else begin
                state <= RUN;
              end
            end
          end
          RUN: begin
            acc <= step_next;
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) begin
              state      <= DONE;
              hi_o       <= final_hi;
              lo_o       <= final_lo;
              div_zero_o <= 1'b0;
              done_o     <= 1'b1;
            end
          end
          DONE:    state <= IDLE;
          DZERO:   state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: hand-computed MULT/DIV vectors, latency,
// stall window, divide-by-zero, annul and mid-operation reset.
module tb_ex_muldiv;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         annul;
  logic         stallreq;
  logic         done_o;
  logic [W-1:0] hi_o;
  logic [W-1:0] lo_o;
  logic         div_zero_o;

  int checks = 0;
  int errors = 0;
  int cyc;
  int stl;
  int pulses;

  ex_muldiv #(.DATA_W(W), .CNT_W(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .start_i    (start),
    .op_i       (op),
    .opdata1_i  (a),
    .opdata2_i  (b),
    .annul_i    (annul),
    .stallreq   (stallreq),
    .done_o     (done_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o),
    .div_zero_o (div_zero_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issues one op and returns in the cycle done_o is high (or after a timeout)
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    #1;
    stl = int'(stallreq);
    tick();
    start = 1'b0;
    cyc   = 1;
    while (!done_o && cyc < 100) begin
      stl += int'(stallreq);
      tick();
      cyc++;
    end
    $display("op=%0d a=%08h b=%08h -> hi=%08h lo=%08h dz=%0d cycles=%0d stall=%0d",
             o, x, y, hi_o, lo_o, div_zero_o, cyc, stl);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; annul = 1'b0; op = 2'b00; a = '0; b = '0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_hi", hi_o, 0);
    chk("rst_lo", lo_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_dz", div_zero_o, 0);
    chk("rst_stall", stallreq, 0);

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu_lat", cyc, 33);
    chk("multu_stall", stl, 33);
    chk("multu_hi", hi_o, 32'hFFFF_FFFE);
    chk("multu_lo", lo_o, 32'h0000_0001);
    chk("multu_done_stall", stallreq, 0);
    tick();
    chk("done_pulse", done_o, 0);

    run_op(2'b00, 32'hFFFF_FFFD, 32'd7);
    chk("mult_neg_hi", hi_o, 32'hFFFF_FFFF);
    chk("mult_neg_lo", lo_o, 32'hFFFF_FFEB);
    tick();

    run_op(2'b00, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
    chk("mult_nn_hi", hi_o, 32'h0);
    chk("mult_nn_lo", lo_o, 32'd6);
    tick();

    run_op(2'b10, 32'hFFFF_FFF9, 32'd2);
    chk("div_neg_lo", lo_o, 32'hFFFF_FFFD);
    chk("div_neg_hi", hi_o, 32'hFFFF_FFFF);
    tick();

    run_op(2'b10, 32'd7, 32'hFFFF_FFFE);
    chk("div_negd_lo", lo_o, 32'hFFFF_FFFD);
    chk("div_negd_hi", hi_o, 32'd1);
    tick();

    run_op(2'b11, 32'd100, 32'd0);
    chk("dz_lat", cyc, 1);
    chk("dz_stall", stl, 1);
    chk("dz_hi", hi_o, 0);
    chk("dz_lo", lo_o, 0);
    chk("dz_flag", div_zero_o, 1);
    tick();
    chk("dz_sticky", div_zero_o, 1);
    chk("dz_pulse", done_o, 0);

    run_op(2'b11, 32'd100, 32'd7);
    chk("divu_lat", cyc, 33);
    chk("divu_lo", lo_o, 32'd14);
    chk("divu_hi", hi_o, 32'd2);
    chk("divu_dz_clr", div_zero_o, 0);
    tick();

    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("minint_lo", lo_o, 32'h8000_0000);
    chk("minint_hi", hi_o, 32'h0);
    chk("minint_dz", div_zero_o, 0);
    tick();

    // Seed HI/LO = 0x11/0x22, then annul a MULTU in its tenth RUN cycle
    run_op(2'b11, 32'h0000_2211, 32'h0000_0100);
    chk("seed_hi", hi_o, 32'h11);
    chk("seed_lo", lo_o, 32'h22);
    tick();
    op = 2'b01; a = 32'd5; b = 32'd6; start = 1'b1;
    tick();
    pulses = 0;
    for (int c = 1; c < 10; c++) begin
      start = (c == 4 || c == 5);
      if (c == 4) begin
        op = 2'b11;
        a  = 32'd9;
        b  = 32'd0;
      end
      #1;
      if (c == 5) chk("run_stall", stallreq, 1);
      if (done_o) pulses++;
      tick();
    end
    start = 1'b0;
    annul = 1'b1;
    tick();
    annul = 1'b0;
    #1;
    chk("annul_stall", stallreq, 0);
    chk("annul_done", done_o, 0);
    chk("annul_hi", hi_o, 32'h11);
    chk("annul_lo", lo_o, 32'h22);
    for (int c = 0; c < 40; c++) begin
      if (done_o) pulses++;
      tick();
    end
    chk("annul_pulses", pulses, 0);
    chk("annul_hi_hold", hi_o, 32'h11);
    chk("annul_lo_hold", lo_o, 32'h22);
    $display("annul: pulses=%0d hi=%08h lo=%08h", pulses, hi_o, lo_o);

    // Reset in the middle of a DIVU
    op = 2'b11; a = 32'd1000; b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    chk("mid_stall", stallreq, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("mrst_hi", hi_o, 0);
    chk("mrst_lo", lo_o, 0);
    chk("mrst_done", done_o, 0);
    chk("mrst_dz", div_zero_o, 0);
    chk("mrst_stall", stallreq, 0);
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      if (done_o) pulses++;
      tick();
    end
    chk("mrst_pulses", pulses, 0);
    $display("reset mid-op: hi=%08h lo=%08h pulses=%0d", hi_o, lo_o, pulses);

    // Back-to-back MULTU separated only by the DONE cycle
    run_op(2'b01, 32'h0000_1234, 32'h0000_5678);
    chk("b2b1_lat", cyc, 33);
    chk("b2b1_hi", hi_o, 32'h0);
    chk("b2b1_lo", lo_o, 32'h0626_0060);
    tick();
    run_op(2'b01, 32'hFFFF_0000, 32'h0001_0000);
    chk("b2b2_lat", cyc, 33);
    chk("b2b2_hi", hi_o, 32'h0000_FFFF);
    chk("b2b2_lo", lo_o, 32'h0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
Parametrised multi-cycle multiply/divide unit for the EX stage. It handles the MULT, MULTU, DIV and DIVU operations that the single-cycle ALU cannot complete in one cycle. Results go into internal HI/LO registers. While an operation is in flight, the unit drives a stall request back to the pipeline controller.

Parameters:
DATA_W, 32, operand width; HI and LO are each DATA_W bits wide.
CNT_W, 6, iteration-counter width; must satisfy 2**CNT_W > DATA_W.

Ports:
clk  in  1  pipeline clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high (`Enable); clears all state.
start_i  in  1  operation request from EX; sampled only in IDLE.
op_i  in  2  operation code: 00=MULT, 01=MULTU, 10=DIV, 11=DIVU.
opdata1_i  in  DATA_W  rs operand (multiplicand or dividend).
opdata2_i  in  DATA_W  rt operand (multiplier or divisor).
annul_i  in  1  flush request (exception or branch squash); aborts the op in flight.
stallreq  out  1  combinational stall request to the pipeline controller.
done_o  out  1  one-cycle pulse; hi_o and lo_o are updated in the same cycle.
hi_o  out  DATA_W  HI register.
lo_o  out  DATA_W  LO register.
div_zero_o  out  1  sticky flag; set when the last completed op was a divide by 0.

Behaviour:
- Reset (clk edge with reset=1): state goes to IDLE; hi_o, lo_o, done_o, div_zero_o and the counter are all cleared to 0. Reset mid-operation discards the op with no HI/LO update.
- State machine:
  - IDLE:
    - On start_i=1 and annul_i=0: latch operands and op_i.
    - For signed ops, convert operands to magnitudes and record the result signs.
    - Counter is set to DATA_W.
    - If op is DIV/DIVU and opdata2_i==0, go to DZERO; otherwise go to RUN.
  - RUN:
    - Multiply: one shift-add step per cycle on a 2*DATA_W accumulator.
    - Divide: one restoring-divide step per cycle (shift the partial remainder, trial-subtract, set the quotient bit).
    - Counter decrements each cycle; when it reaches 1, the next state is DONE.
  - DONE (one cycle):
    - Apply sign correction and write hi_o/lo_o.
    - done_o=1 and div_zero_o=0.
    - Next state is IDLE.
  - DZERO (one cycle): hi_o=lo_o=0, div_zero_o=1, done_o=1, next state IDLE.
- Latency:
  - start_i sampled at edge t gives done_o high in the cycle after edge t+DATA_W (DATA_W RUN cycles plus one DONE cycle).
  - A divide by zero gives done_o one cycle after acceptance.
- stallreq is combinational:
  - 1 when (IDLE and start_i and not annul_i), or in RUN.
  - 0 in DONE, DZERO and IDLE without a request.
  - This lets the instruction advance in the cycle its result lands.
- Result mapping:
  - MULT/MULTU: {hi_o,lo_o} = full 2*DATA_W product. MULT negates the product when the operand signs differ (two's complement).
  - DIV/DIVU: lo_o = quotient, hi_o = remainder.
  - DIV sign rules: negate the quotient when the signs differ; the remainder takes the dividend's sign.
  - DIV of MIN_INT by -1: lo_o=MIN_INT (wraps), hi_o=0, no flag.
- annul_i:
  - Any state: next state is IDLE, done_o=0, and HI/LO/div_zero_o are unchanged.
  - annul_i dominates start_i in the same cycle.
- start_i is ignored outside IDLE, and operands are not re-sampled while RUN is active.
- hi_o and lo_o hold their values between done_o pulses.

Test Plan:
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> done_o 33 cycles after start; hi_o=0xFFFFFFFE, lo_o=0x00000001; stallreq high for exactly 33 cycles (acceptance cycle plus 32 RUN cycles).
- MULT 0xFFFFFFFD(-3)*7 -> hi_o=0xFFFFFFFF, lo_o=0xFFFFFFEB (-21); DIV -7/2 -> lo_o=0xFFFFFFFD (-3), hi_o=0xFFFFFFFF (-1).
- DIVU 100/0 -> done_o one cycle after acceptance; hi_o=lo_o=0, div_zero_o=1; a following DIVU 100/7 -> lo_o=14, hi_o=2, div_zero_o=0.
- DIV 0x80000000/0xFFFFFFFF -> lo_o=0x80000000, hi_o=0, div_zero_o=0.
- Start MULTU 5*6 after a prior result HI/LO=0x11/0x22; assert annul_i at RUN cycle 10 -> IDLE next cycle, no done_o, HI/LO stay 0x11/0x22; start pulses during RUN are ignored.
- Assert reset mid-DIVU -> all outputs 0 on the next edge; back-to-back MULTU ops separated by the DONE cycle both complete correctly.
